// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program loader port, cpu fetch request and instruction return.
// fetch_req is taken only while busy==0 (busy is the inverse of ready); instr_valid/fault are one-cycle strobes with no backpressure.
interface instr_fetch_if #(
   parameter int ADDR_W = 8
);
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              fetch_req;
   logic [31:0]       pc_in;
   logic [31:0]       instruction;
   logic              instr_valid;
   logic              busy;
   logic              fault;
   logic [2:0]        state_dbg;

   modport master (
      output ld_en, ld_addr, ld_data, fetch_req, pc_in,
      input  instruction, instr_valid, busy, fault, state_dbg
   );

   modport slave (
      input  ld_en, ld_addr, ld_data, fetch_req, pc_in,
      output instruction, instr_valid, busy, fault, state_dbg
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: byte-wide program memory read one byte per cycle,
// assembled big-endian into a 32-bit word delivered with a one-cycle strobe.
module instr_fetch #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   instr_fetch_if.slave bus
);

   localparam int                MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0]       LAST_PC  = 32'(DEPTH - 4);
   localparam logic [ADDR_W:0]   DEPTH_LD = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      B0   = 3'd1,
      B1   = 3'd2,
      B2   = 3'd3,
      B3   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;

   logic [7:0]  mem [DEPTH];

   logic [1:0]  byte_idx;
   logic [31:0] rd_addr;
   logic [7:0]  rd_byte;
   logic        req_illegal;
   logic        ld_in_range;
   logic        unused_rd_bits;

   // The range check keeps addr_q+3 below DEPTH, so the upper address bits never select anything.
   always_comb begin
      byte_idx = 2'd0;
      case (state_q)
         B0:      byte_idx = 2'd0;
         B1:      byte_idx = 2'd1;
         B2:      byte_idx = 2'd2;
         B3:      byte_idx = 2'd3;
         default: byte_idx = 2'd0;
      endcase
   end

   assign rd_addr        = addr_q + {30'd0, byte_idx};
   assign rd_byte        = mem[rd_addr[MEM_AW-1:0]];
   assign unused_rd_bits = ^rd_addr[31:MEM_AW];

   assign req_illegal = (bus.pc_in[1:0] != 2'b00) || (bus.pc_in > LAST_PC);
   assign ld_in_range = ({1'b0, bus.ld_addr} < DEPTH_LD);

   // Memory has no reset; the combinational read above sees the pre-write byte.
   always_ff @(posedge clk) begin
      if (bus.ld_en && ld_in_range) begin
         mem[bus.ld_addr[MEM_AW-1:0]] <= bus.ld_data;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      shift_d = shift_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      fault_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.fetch_req) begin
               addr_d = bus.pc_in;
               if (req_illegal) begin
                  instr_d = 32'h0;
                  valid_d = 1'b1;
                  fault_d = 1'b1;
               end else begin
                  state_d = B0;
               end
            end
         end
         B0: begin
            shift_d = {shift_q[15:0], rd_byte};
            state_d = B1;
         end
         B1: begin
            shift_d = {shift_q[15:0], rd_byte};
            state_d = B2;
         end
         B2: begin
            shift_d = {shift_q[15:0], rd_byte};
            state_d = B3;
         end
         B3: begin
            instr_d = {shift_q, rd_byte};
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         shift_q <= 24'h0;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         shift_q <= shift_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.fault       = fault_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of memory and fetches.
module tb_instr_fetch;

   localparam int DEPTH  = 128;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  m_mem [DEPTH];
   logic        m_fetching = 1'b0;
   int          m_cnt      = 0;
   logic [31:0] m_pc       = 32'h0;
   logic [7:0]  m_bytes [4];
   logic [31:0] m_instr    = 32'h0;
   logic        m_valid    = 1'b0;
   logic        m_fault    = 1'b0;
   logic [32:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: a fetch collects bytes pc..pc+3 on the four edges after acceptance,
   // each read before that edge's loader write lands.
   task automatic model_step();
      if (!rst) begin
         m_fetching = 1'b0;
         m_cnt      = 0;
         m_instr    = 32'h0;
         m_valid    = 1'b0;
         m_fault    = 1'b0;
      end else begin
         m_valid = 1'b0;
         m_fault = 1'b0;
         if (m_fetching) begin
            m_bytes[m_cnt] = m_mem[int'(m_pc) + m_cnt];
            m_cnt++;
            if (m_cnt == 4) begin
               m_fetching = 1'b0;
               m_instr    = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_valid    = 1'b1;
               exp_q.push_back({1'b0, m_instr});
            end
         end else if (bus.fetch_req) begin
            if ((bus.pc_in % 4 != 0) || (bus.pc_in > 32'(DEPTH - 4))) begin
               m_instr = 32'h0;
               m_valid = 1'b1;
               m_fault = 1'b1;
               exp_q.push_back({1'b1, 32'h0});
            end else begin
               m_fetching = 1'b1;
               m_cnt      = 0;
               m_pc       = bus.pc_in;
            end
         end
      end
      if (bus.ld_en && (int'(bus.ld_addr) < DEPTH)) m_mem[int'(bus.ld_addr)] = bus.ld_data;
   endtask

   task automatic compare();
      logic [32:0] e;
      check("busy",  32'(bus.busy),        32'(m_fetching));
      check("valid", 32'(bus.instr_valid), 32'(m_valid));
      check("fault", 32'(bus.fault),       32'(m_fault));
      check("instr", bus.instruction,      m_instr);
      if (bus.instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_valid", 32'(bus.instr_valid), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("sb_word",  bus.instruction, e[31:0]);
            check("sb_fault", 32'(bus.fault),  32'(e[32]));
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic load(input int a, input logic [7:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_addr = ADDR_W'(a);
      bus.ld_data = d;
      cycle();
      bus.ld_en   = 1'b0;
   endtask

   task automatic request(input logic [31:0] pc);
      bus.fetch_req = 1'b1;
      bus.pc_in     = pc;
      cycle();
      bus.fetch_req = 1'b0;
   endtask

   task automatic finish_fetch();
      repeat (3) cycle();
      cycle();
   endtask

   initial begin
      int gap;
      int n_valid;
      logic [31:0] bad_pc [4];

      bus.ld_en     = 1'b0;
      bus.ld_addr   = '0;
      bus.ld_data   = 8'h0;
      bus.fetch_req = 1'b0;
      bus.pc_in     = 32'h0;

      rst = 1'b0;
      repeat (2) cycle();
      check("rst_busy",  32'(bus.busy), 32'h0);
      check("rst_valid", 32'(bus.instr_valid), 32'h0);
      check("rst_instr", bus.instruction, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom_range(0, 255)));

      // Single fetch: four busy cycles, then the word.
      load(0, 8'h81); load(1, 8'h02); load(2, 8'h03); load(3, 8'h04);
      request(32'h0);
      check("t1_busy0", 32'(bus.busy), 32'h1);
      for (int i = 1; i < 4; i++) begin
         cycle();
         check("t1_busy", 32'(bus.busy), 32'h1);
      end
      cycle();
      check("t1_valid", 32'(bus.instr_valid), 32'h1);
      check("t1_word",  bus.instruction, 32'h81020304);
      check("t1_fault", 32'(bus.fault), 32'h0);
      cycle();
      check("t1_strobe_len", 32'(bus.instr_valid), 32'h0);

      // Re-request in the valid cycle: accepted on the next edge, so strobes are 5 edges apart.
      load(4, 8'hA0); load(5, 8'h01); load(6, 8'h02); load(7, 8'h05);
      request(32'h0);
      finish_fetch();
      check("t2_first", bus.instruction, 32'h81020304);
      bus.fetch_req = 1'b1;
      bus.pc_in     = 32'h4;
      gap = 0;
      do begin
         cycle();
         bus.fetch_req = 1'b0;
         gap++;
      end while (bus.instr_valid !== 1'b1 && gap < 12);
      check("t2_gap",  32'(gap), 32'h5);
      check("t2_word", bus.instruction, 32'hA0010205);
      cycle();

      // Illegal requests fault on the next cycle without going busy.
      bad_pc[0] = 32'h2;
      bad_pc[1] = 32'hFFFF_FFFC;
      bad_pc[2] = 32'(DEPTH - 2);
      bad_pc[3] = 32'(DEPTH);
      for (int i = 0; i < 4; i++) begin
         request(bad_pc[i]);
         check("t3_valid", 32'(bus.instr_valid), 32'h1);
         check("t3_fault", 32'(bus.fault), 32'h1);
         check("t3_word",  bus.instruction, 32'h0);
         check("t3_busy",  32'(bus.busy), 32'h0);
         cycle();
      end

      // Request pulsed during B1 is ignored.
      request(32'h0);
      cycle();
      request(32'h4);
      n_valid = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (bus.instr_valid === 1'b1) begin
            n_valid++;
            check("t4_word", bus.instruction, 32'h81020304);
         end
      end
      check("t4_count", 32'(n_valid), 32'h1);

      // Loader write to the byte being read in B2 returns the old byte.
      request(32'h0);
      cycle();
      cycle();
      bus.ld_en   = 1'b1;
      bus.ld_addr = ADDR_W'(2);
      bus.ld_data = 8'hFF;
      cycle();
      bus.ld_en   = 1'b0;
      cycle();
      check("t5_old", bus.instruction, 32'h81020304);
      request(32'h0);
      finish_fetch();
      check("t5_new", bus.instruction, 32'h8102FF04);

      // Reset during B1 aborts the fetch; memory survives.
      request(32'h0);
      cycle();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      check("t6_busy",  32'(bus.busy), 32'h0);
      check("t6_instr", bus.instruction, 32'h0);
      check("t6_valid", 32'(bus.instr_valid), 32'h0);
      repeat (5) cycle();
      request(32'h0);
      finish_fetch();
      check("t6_retained", bus.instruction, 32'h8102FF04);

      // Random traffic, including out-of-range loader writes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.fetch_req = ($urandom_range(0, 9) < 6);
         case ($urandom_range(0, 9))
            0:       bus.pc_in = 32'($urandom_range(0, DEPTH - 1));
            1:       bus.pc_in = 32'hFFFF_FFFC;
            2:       bus.pc_in = 32'(DEPTH + 4 * $urandom_range(0, 15));
            3:       bus.pc_in = 32'(DEPTH - 4);
            default: bus.pc_in = 32'(4 * $urandom_range(0, DEPTH / 4 - 1));
         endcase
         bus.ld_en   = ($urandom_range(0, 9) < 3);
         bus.ld_addr = ADDR_W'($urandom_range(0, 255));
         bus.ld_data = 8'($urandom_range(0, 255));
         rst         = ($urandom_range(0, 99) != 0);
         cycle();
      end
      bus.fetch_req = 1'b0;
      bus.ld_en     = 1'b0;
      rst           = 1'b1;
      repeat (6) cycle();
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
